rf_scan_ctrl: RTL
=================

RF_SCAN_CTRL -- requirements
Module: rf_scan_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width (32 entries).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter SKIP_R0, default 1, which suppresses register-file writes to address 0 when 1.
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when both high.
REQ-008 cmd_op  input  1  0 = dump (read registers out), 1 = load (write registers in).
REQ-009 cmd_addr  input  ADDR_W  first register address.
REQ-010 cmd_cnt  input  ADDR_W  word count minus one (N = cmd_cnt+1, 1..32).
REQ-011 out_valid / out_ready / out_data  output / input / output  1 / 1 / DATA_W  dump stream.
REQ-012 in_valid / in_ready / in_data  input / output / input  1 / 1 / DATA_W  load stream.
REQ-013 rf_rd_addr  output  ADDR_W  drives register-file read port 1 (combinational read, data same cycle).
REQ-014 rf_rd_data  input  DATA_W  register-file read data 1.
REQ-015 rf_we / rf_wr_addr / rf_wr_data  output  1 / ADDR_W / DATA_W  drive register-file RegWrite / wr_addr / wr_data.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse at command completion.

Function
REQ-018 SHALL implement states IDLE, DUMP, LOAD; cmd_ready = 1 only in IDLE.
REQ-019 SHALL, on a cmd handshake in cycle T, latch addr/cnt and enter DUMP (op=0) or LOAD (op=1) at T+1.
REQ-020 SHALL ignore cmd_valid outside IDLE, with no side effects.
REQ-021 SHALL advance the current address modulo 2^ADDR_W per word (31 -> 0 wrap).
REQ-022 DUMP: SHALL drive rf_rd_addr = current fetch address and capture rf_rd_data into the out_data register whenever that register is empty or being consumed (out_valid && out_ready) and fetches remain.
REQ-023 DUMP: SHALL present the first word (register cmd_addr) with out_valid high at T+2; with out_ready held high, throughput is 1 word/cycle.
REQ-024 DUMP: while out_valid && !out_ready, out_data, out_valid and rf_rd_addr SHALL hold stable.
REQ-025 DUMP: after the Nth out handshake, SHALL drop out_valid, pulse done for one cycle in the next cycle, and return to IDLE in that same cycle.
REQ-026 LOAD: SHALL assert in_ready for exactly N handshakes; for each, rf_we/rf_wr_addr/rf_wr_data are registered and asserted for one cycle, in the cycle after the handshake.
REQ-027 LOAD: when SKIP_R0 = 1 and the address is 0, SHALL consume the word and advance the address but keep rf_we = 0.
REQ-028 LOAD: done SHALL pulse in the cycle the Nth write is on the port; the state returns to IDLE in that same cycle.
REQ-029 SHALL keep rf_we = 0 in all states except the write cycle of REQ-026.
REQ-030 SHALL guarantee that a dump accepted in the cycle after a load's done reads the newly written values.

Reset
REQ-031 With rst high at a posedge, SHALL go to IDLE and clear out_valid, in_ready, rf_we, done, busy and rf_rd_addr/rf_wr_addr/rf_wr_data/out_data to 0; cmd_ready = 1 after reset.
REQ-032 Reset mid-command SHALL abort the command and discard in-flight words; no rf_we pulse occurs during or after reset for the aborted command.

Verification
REQ-033 Load addr=4, cnt=2, in_data 0xA, 0xB, 0xC with in_valid continuous -> rf_we pulses at regs 4, 5, 6 on consecutive cycles; done pulses with the third write.
REQ-034 Dump addr=30, cnt=3 with RF[30]=0x1E, RF[31]=0x1F, RF[0]=0, RF[1]=0x11 and out_ready high -> out_data 0x1E, 0x1F, 0x0, 0x11 on 4 consecutive cycles starting at T+2; done one cycle after the last.
REQ-035 Dump cnt=1 with out_ready low for 5 cycles after first out_valid -> word 0 held stable; no word lost or duplicated after release.
REQ-036 Load addr=31, cnt=1, SKIP_R0=1, data 0x55, 0x66 -> RF[31]=0x55; RF[0] unchanged; 2 in handshakes; exactly 1 rf_we pulse.
REQ-037 Reset asserted mid-load after 1 of 4 words -> IDLE next cycle; rf_we stays 0; cmd_ready = 1; a new command then completes normally.
REQ-038 cmd_valid pulsed during DUMP -> ignored; cmd_ready = 0; dump output unchanged.

Source files
------------

// File: rtl/rf_scan_ctrl.sv
// Scan controller that streams a register-file window out (dump) or in (load).
// Addresses wrap modulo 2^ADDR_W; a load never writes address 0 when SKIP_R0 is set.
module rf_scan_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter bit          SKIP_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [ADDR_W-1:0] cmd_cnt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [ADDR_W-1:0] rf_rd_addr_o,
    input  logic [DATA_W-1:0] rf_rd_data_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_wr_addr_o,
    output logic [DATA_W-1:0] rf_wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {StIdle, StDump, StLoad} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Words still to fetch (dump) or to accept (load).
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;

    logic fetch, consume, in_hs, rem_nz;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        we_d        = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;

        rem_nz  = (rem_q != '0);
        consume = out_valid_q && out_ready_i;
        // The output register refills whenever it is empty or draining this cycle.
        fetch   = (state_q == StDump) && rem_nz && (!out_valid_q || out_ready_i);
        in_hs   = (state_q == StLoad) && rem_nz && in_valid_i;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    rem_d   = {1'b0, cmd_cnt_i} + (ADDR_W + 1)'(1);
                    state_d = cmd_op_i ? StLoad : StDump;
                end
            end
            StDump: begin
                if (fetch) begin
                    out_data_d  = rf_rd_data_i;
                    out_valid_d = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    rem_d       = rem_q - (ADDR_W + 1)'(1);
                end else if (consume) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            StLoad: begin
                if (in_hs) begin
                    we_d      = !(SKIP_R0 && (addr_q == '0));
                    wr_addr_d = addr_q;
                    wr_data_d = in_data_i;
                    addr_d    = addr_q + ADDR_W'(1);
                    rem_d     = rem_q - (ADDR_W + 1)'(1);
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            we_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            we_q        <= we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign in_ready_o   = (state_q == StLoad) && (rem_q != '0);
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign rf_rd_addr_o = addr_q;
    assign rf_we_o      = we_q;
    assign rf_wr_addr_o = wr_addr_q;
    assign rf_wr_data_o = wr_data_q;
    assign done_o       = done_q;

endmodule
